// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with a multi-cycle execute stall.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl_mc #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned PCSRC_W = 2,
    parameter int unsigned MC_LAT  = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_AW-1:0]  rs1_d,
    input  logic [REG_AW-1:0]  rs2_d,
    input  logic [REG_AW-1:0]  rs1_e,
    input  logic [REG_AW-1:0]  rs2_e,
    input  logic [REG_AW-1:0]  rd_e,
    input  logic [REG_AW-1:0]  rd_m,
    input  logic [REG_AW-1:0]  rd_w,
    input  logic               reg_write_m,
    input  logic               reg_write_w,
    input  logic               load_e,
    input  logic               mc_start_e,
    input  logic [PCSRC_W-1:0] pc_src_e,
    output logic [1:0]         forward_a_e,
    output logic [1:0]         forward_b_e,
    output logic               stall_f,
    output logic               stall_d,
    output logic               stall_e,
    output logic               flush_d,
    output logic               flush_e,
    output logic               flush_m,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [31:0]        perf_lu,
    output logic [31:0]        perf_mc,
    output logic [31:0]        perf_fl
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_BUSY   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);
    localparam logic             MC_MULTI = (MC_LAT > 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_mcs;
    logic             w_done;
    logic             w_lu;
    logic             w_br;
    logic             w_run;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdm,
        input logic              rwm,
        input logic [REG_AW-1:0] rdw,
        input logic              rww
    );
        if (rs == '0)              return 2'b00;
        else if (rwm && rs == rdm) return 2'b10;
        else if (rww && rs == rdw) return 2'b01;
        else                       return 2'b00;
    endfunction

    assign forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    // x0 never creates a load-use dependency
    assign w_lu = load_e && (rd_e != '0) &&
                  (((rs1_d == rd_e) && (rs1_d != '0)) || ((rs2_d == rd_e) && (rs2_d != '0)));
    assign w_br = (pc_src_e != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Countdown: start cycle stalls, then BUSY stalls while cnt > 1 and finishes at cnt == 1
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_mcs      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mc_start_e) begin
                    if (MC_MULTI) begin
                        w_mcs      = 1'b1;
                        w_state_nx = S_BUSY;
                        w_cnt_nx   = CNT_LOAD;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_cnt_nx = r_cnt - CNT_W'(1);
                w_mcs    = (r_cnt > CNT_W'(1));
                if (r_cnt == CNT_W'(1)) begin
                    w_done     = 1'b1;
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Control outputs are forced low for the whole time reset is held
    assign w_run   = ~rst;
    assign stall_f = w_run & (w_lu | w_mcs);
    assign stall_d = w_run & (w_lu | w_mcs);
    assign stall_e = w_run & w_mcs;
    assign flush_d = w_run & w_br & ~w_mcs;
    assign flush_e = w_run & (w_lu | w_br) & ~w_mcs;
    assign flush_m = w_run & w_mcs;
    assign mc_busy = w_run & (r_state == S_BUSY);
    assign mc_done = w_run & w_done;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_mc;
    logic [31:0] r_perf_fl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_lu <= '0;
            r_perf_mc <= '0;
            r_perf_fl <= '0;
        end else begin
            if (w_lu)    r_perf_lu <= r_perf_lu + 32'd1;
            if (w_mcs)   r_perf_mc <= r_perf_mc + 32'd1;
            if (flush_d) r_perf_fl <= r_perf_fl + 32'd1;
        end
    end

    assign perf_lu = r_perf_lu;
    assign perf_mc = r_perf_mc;
    assign perf_fl = r_perf_fl;
`else
    assign perf_lu = '0;
    assign perf_mc = '0;
    assign perf_fl = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc (MC_LAT = 4): vector table plus multi-cycle,
// reset and perf-counter sequences; expected words flow through a scoreboard queue.
module tb_hazard_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        reg_write_m, reg_write_w, load_e, mc_start_e;
    logic [1:0]  pc_src_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy, mc_done;
    logic [31:0] perf_lu, perf_mc, perf_fl;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(5), .PCSRC_W(2), .MC_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .load_e(load_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .mc_busy(mc_busy), .mc_done(mc_done),
        .perf_lu(perf_lu), .perf_mc(perf_mc), .perf_fl(perf_fl)
    );

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       rwm, rww, ld, mc;
        logic [1:0] pc;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [11:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[11];
    int   checks = 0;
    int   errors = 0;

    logic [11:0] act;
    assign act = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
                  flush_d, flush_e, flush_m, mc_busy, mc_done};

    function automatic logic [11:0] ow(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic bz, input logic dn);
        return {fa, fb, sf, sd, se, fd, fe, fm, bz, dn};
    endfunction

    function automatic in_t mk(input logic [4:0] a_rs1_d, input logic [4:0] a_rs2_d,
                               input logic [4:0] a_rs1_e, input logic [4:0] a_rs2_e,
                               input logic [4:0] a_rd_e, input logic [4:0] a_rd_m,
                               input logic [4:0] a_rd_w, input logic a_rwm, input logic a_rww,
                               input logic a_ld, input logic a_mc, input logic [1:0] a_pc);
        in_t v;
        v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
        v.rd_e  = a_rd_e;  v.rd_m  = a_rd_m;  v.rd_w  = a_rd_w;
        v.rwm = a_rwm; v.rww = a_rww; v.ld = a_ld; v.mc = a_mc; v.pc = a_pc;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
        reg_write_m = v.rwm; reg_write_w = v.rww; load_e = v.ld;
        mc_start_e = v.mc; pc_src_e = v.pc;
    endtask

    task automatic expect_out(input string nm, input logic [11:0] e);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check_out();
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry for output %b", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got {fa,fb,sf,sd,se,fd,fe,fm,busy,done}=%b expected %b",
                         s.name, act, s.exp);
            end
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // One pipeline cycle: drive after the edge, check on the falling edge
    task automatic step(input string nm, input in_t v, input logic [11:0] e);
        @(posedge clk);
        #1;
        drive(v);
        expect_out(nm, e);
        @(negedge clk);
        check_out();
    endtask

    in_t z;
    in_t mcv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        z   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mcv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        vecs[0]  = '{"fwd_m_over_w", mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0), ow(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{"fwd_w",        mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 0, 0, 0), ow(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{"fwd_x0",       mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), ow(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{"fwd_a_w_b_m",  mk(0, 0, 4, 3, 0, 3, 4, 1, 1, 0, 0, 0), ow(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{"fwd_none",     mk(0, 0, 6, 6, 0, 6, 7, 0, 1, 0, 0, 0), ow(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{"lu_rs2",       mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0), ow(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0)};
        vecs[6]  = '{"lu_rs1",       mk(9, 0, 0, 0, 9, 0, 0, 0, 0, 1, 0, 0), ow(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0)};
        vecs[7]  = '{"lu_rd_x0",     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ow(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{"lu_no_load",   mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0), ow(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"branch",       mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ow(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0)};
        vecs[10] = '{"branch_lu",    mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 2), ow(2'b00, 2'b00, 1, 1, 0, 1, 1, 0, 0, 0)};

        // Reset: controls low even with mc_start_e high; forwarding still live
        rst = 1'b1;
        drive(mk(0, 0, 5, 0, 0, 5, 0, 1, 0, 0, 1, 0));
        #3;
        expect_out("reset_state", ow(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        check_out();
        drive(z);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].name, vecs[i].in, vecs[i].exp);
        end

        // Multi-cycle op held in E for 4 cycles: 3 stalls, done in the 4th
        step("mc_c1", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        step("mc_c2", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        step("mc_c3", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        step("mc_c4", mcv, ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step("mc_c5", z,   ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Branch with mc start: flush deferred until mcs drops; mcs beats lu
        step("mcbr_c1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ow(0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        step("mcbr_c2_lu", mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1), ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        step("mcbr_c3", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        step("mcbr_c4", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ow(0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
        step("mcbr_c5", z, ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset in the 2nd BUSY cycle drops stalls/busy asynchronously
        step("rstmc_c1", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        @(posedge clk);
        #1;
        expect_out("rstmc_c2_busy", ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        check_out();
        #1;
        rst = 1'b1;
        #1;
        expect_out("rstmc_async_drop", ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_out();
        drive(z);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("rstmc_released_idle", ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_out();
        step("rstmc_idle_next", z, ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rstmc_restart", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        step("rstmc_restart_busy", z, ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));

        // Perf: one load-use, one 4-cycle op, one branch after a fresh reset
        @(negedge clk);
        rst = 1'b1;
        drive(z);
        @(negedge clk);
        rst = 1'b0;
        step("perf_lu_cyc", vecs[5].in, vecs[5].exp);
        step("perf_mc_c1", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        step("perf_mc_c2", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        step("perf_mc_c3", mcv, ow(0, 0, 1, 1, 1, 0, 0, 1, 1, 0));
        step("perf_mc_c4", mcv, ow(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step("perf_gap", z, ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("perf_br", vecs[9].in, vecs[9].exp);
        step("perf_tail", z, ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        check_val("perf_lu", perf_lu, 32'd1);
        check_val("perf_mc", perf_mc, 32'd3);
        check_val("perf_fl", perf_fl, 32'd1);
`else
        check_val("perf_lu_tied", perf_lu, 32'd0);
        check_val("perf_mc_tied", perf_mc, 32'd0);
        check_val("perf_fl_tied", perf_fl, 32'd0);
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
